// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : axis_sync_fifo
//  Brief    : Single-clock AXI4-Stream FIFO with first-word-fall-through
//             output and occupancy count. Buffers DATA_WIDTH-bit beats
//             between the word serialiser and the PS-facing stream.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       rst,
  input  logic                       clk,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     count
);

  // Address bits index the array; the extra pointer MSB tells full from empty.
  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_PTR_W  = c_ADDR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Status decode: equal pointers mean empty; differing only in MSB means full.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
              (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  end

  // Handshakes. Ready is held low in reset so no beat is taken in that cycle,
  // and it does not look at the consumer: a full FIFO refuses even while popping.
  always_comb begin
    s_axis_tready = !w_full && !rst;
    m_axis_tvalid = !w_empty && !rst;
    w_push        = s_axis_tvalid && s_axis_tready;
    w_pop         = m_axis_tvalid && m_axis_tready;
  end

  // Head data falls through combinationally; occupancy is the pointer distance.
  always_comb begin
    m_axis_tdata = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    count        = r_wr_ptr - r_rd_ptr;
  end

  // Storage write; contents are intentionally left uncleared by reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= s_axis_tdata;
    end
  end

  // Pointer update; natural wrap of the extended pointer gives modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_sync_fifo
//  Brief    : Self-checking bench for axis_sync_fifo using a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  int            n_push = 0;
  int            n_pop  = 0;

  axis_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .rst           (rst),
    .clk           (clk),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .count         (count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a FIFO queue updated on each edge from the pre-edge inputs.
  always @(posedge clk) begin
    logic do_push;
    logic do_pop;
    logic [DW-1:0] tmp;
    if (rst) begin
      mq.delete();
    end else begin
      do_push = s_axis_tvalid && (mq.size() < DEPTH);
      do_pop  = m_axis_tready && (mq.size() > 0);
      if (do_pop) begin
        tmp = mq.pop_front();
        n_pop++;
      end
      if (do_push) begin
        mq.push_back(s_axis_tdata);
        n_push++;
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (rst !== 1'bx) begin
      chk("m_tready_model", {31'd0, s_axis_tready}, {31'd0, (!rst && mq.size() < DEPTH)});
      chk("m_tvalid_model", {31'd0, m_axis_tvalid}, {31'd0, (!rst && mq.size() > 0)});
      chk("m_count_model", 32'(count), 32'(mq.size()));
      if (!rst && mq.size() > 0) begin
        chk("m_tdata_model", m_axis_tdata, mq[0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(int n, logic [31:0] base);
    m_axis_tready = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 32'(i);
      cyc();
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    while (m_axis_tvalid && guard < 100) begin
      cyc();
      guard++;
    end
    chk("drain_bound", {31'd0, m_axis_tvalid}, 32'd0);
    m_axis_tready = 1'b0;
  endtask

  initial begin
    int cycles;
    int pushed;
    logic [31:0] seq;

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    #1;
    chk("tready_after_rst", {31'd0, s_axis_tready}, 32'd1);

    // Three words with stalled consumer
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h11111111; cyc();
    s_axis_tdata = 32'h22222222; cyc();
    s_axis_tdata = 32'h33333333; cyc();
    s_axis_tvalid = 1'b0;
    chk("three_count", 32'(count), 32'd3);
    chk("three_head", m_axis_tdata, 32'h11111111);
    m_axis_tready = 1'b1;
    cyc();
    chk("three_word2", m_axis_tdata, 32'h22222222);
    cyc();
    chk("three_word3", m_axis_tdata, 32'h33333333);
    cyc();
    chk("three_empty", {31'd0, m_axis_tvalid}, 32'd0);
    m_axis_tready = 1'b0;

    // Fill to full, attempt overflow, drain
    push_n(16, 32'd0);
    chk("full_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("full_count", 32'(count), 32'd16);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0000DEAD;
    cyc();
    cyc();
    s_axis_tvalid = 1'b0;
    chk("overflow_count", 32'(count), 32'd16);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_value", m_axis_tdata, 32'(i));
      cyc();
    end
    chk("drain_empty", {31'd0, m_axis_tvalid}, 32'd0);
    chk("drain_count", 32'(count), 32'd0);
    m_axis_tready = 1'b0;

    // Streaming at full rate
    m_axis_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h1000 + 32'(i);
      cyc();
      chk("stream_data", m_axis_tdata, 32'h1000 + 32'(i));
      chk("stream_valid", {31'd0, m_axis_tvalid}, 32'd1);
      chk("stream_count", 32'(count), 32'd1);
    end
    s_axis_tvalid = 1'b0;
    cyc();
    chk("stream_end_count", 32'(count), 32'd0);

    // Random valid/ready at 50% for 1000 accepted beats
    n_push = 0;
    n_pop  = 0;
    pushed = 0;
    cycles = 0;
    seq    = 32'h5000_0000;
    while (pushed < 1000 && cycles < 20000) begin
      s_axis_tvalid = 1'($urandom_range(0, 1));
      m_axis_tready = 1'($urandom_range(0, 1));
      s_axis_tdata  = s_axis_tvalid ? seq : $urandom;
      #1;
      if (s_axis_tvalid && s_axis_tready) begin
        seq++;
        pushed++;
      end
      cyc();
      cycles++;
    end
    chk("random_bound", {31'd0, (pushed == 1000)}, 32'd1);
    drain();
    chk("random_pops", 32'(n_pop), 32'(n_push));
    chk("random_wraps", {31'd0, (n_push > 4 * DEPTH)}, 32'd1);

    // Reset mid-stream
    push_n(10, 32'h300);
    chk("pre_rst_count", 32'(count), 32'd10);
    rst = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0BAD0BAD; m_axis_tready = 1'b1;
    cyc();
    chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_tready", {31'd0, s_axis_tready}, 32'd0);
    rst = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tdata = 32'hA5A5A5A5;
    cyc();
    s_axis_tvalid = 1'b0;
    chk("post_rst_head", m_axis_tdata, 32'hA5A5A5A5);
    chk("post_rst_count", 32'(count), 32'd1);
    drain();

    // Stall consumer while full and toggle input data
    push_n(16, 32'h200);
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = $urandom;
      cyc();
      chk("stall_data", m_axis_tdata, 32'h200);
      chk("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
    end
    s_axis_tvalid = 1'b0;
    drain();

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_sync_fifo.md
# axis_sync_fifo

Single-clock AXI4-Stream FIFO that buffers `DATA_WIDTH`-bit beats between an upstream producer and a downstream consumer, with full-throughput handshakes on both sides. It sits in the ADC capture path between the PL word-serialiser (which splits each 128-bit sample word into 32-bit beats) and the PS-facing stream output. It has first-word-fall-through behaviour and exposes an occupancy count.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: beat width in bits; first positional parameter.
- `DEPTH`, default 16: number of entries; must be a power of two and at least 2.

Ports (positional order is rst, clk, s_axis_tvalid, s_axis_tready, s_axis_tdata, m_axis_tdata, m_axis_tvalid, m_axis_tready, count):
- `clk`  in  1: the single clock. One clock; all logic runs on its rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `s_axis_tvalid`  in  1: the producer presents a beat.
- `s_axis_tready`  out  1: the FIFO can accept a beat (not full).
- `s_axis_tdata`  in  DATA_WIDTH: write data.
- `m_axis_tdata`  out  DATA_WIDTH: head-of-FIFO data.
- `m_axis_tvalid`  out  1: the FIFO is non-empty.
- `m_axis_tready`  in  1: the consumer accepts the head beat.
- `count`  out  $clog2(DEPTH)+1: number of stored beats, range 0..DEPTH.

## Operation
- Storage is a DEPTH-entry register array with write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(DEPTH)+1` bits wide. The extra MSB distinguishes full from empty.
- Empty condition: `wr_ptr == rd_ptr`.
- Full condition: the pointers differ only in the MSB.
- Push occurs when `s_axis_tvalid && s_axis_tready`:
  - the beat is written to `mem[wr_ptr[low bits]]`;
  - `wr_ptr` increments and wraps modulo 2*DEPTH.
- Pop occurs when `m_axis_tvalid && m_axis_tready`:
  - `rd_ptr` increments and wraps modulo 2*DEPTH.
- Simultaneous push and pop in the same cycle are both performed; `count` is unchanged.
- `s_axis_tready = !full && !rst`. When the FIFO is full it drops ready, even if a pop occurs in the same cycle; there is no same-cycle pass-through of free space.
- `m_axis_tvalid = !empty`. `m_axis_tdata = mem[rd_ptr[low bits]]`, read combinationally (first-word-fall-through).
- Beats leave in exactly the order they were accepted, with no loss or duplication.
- AXIS compliance: while `m_axis_tvalid` is high and `m_axis_tready` is low, `m_axis_tdata` and `m_axis_tvalid` hold stable.
- The producer's data is sampled only on accepted beats. When `s_axis_tvalid` is low, `s_axis_tdata` is don't-care.
- `count = wr_ptr - rd_ptr`, computed modulo 2*DEPTH.

## Timing
- Reset (`rst` high at a clock edge):
  - `wr_ptr`, `rd_ptr` and `count` go to 0;
  - `m_axis_tvalid` is 0 and `s_axis_tready` is 0 while `rst` is high;
  - `s_axis_tready` rises combinationally once `rst` is low;
  - storage contents are not cleared; `m_axis_tdata` is don't-care while empty.
- Reset mid-operation discards all stored beats. Any handshake in the reset cycle is ignored.
- Write-to-read latency is 1 cycle: a beat accepted at edge N gives `m_axis_tvalid` = 1 after edge N, and it can be popped at edge N+1.
- Sustained throughput is 1 beat per cycle when both sides are continuously valid/ready.
- Full: after DEPTH pushes with no pops, `s_axis_tready` goes low after the edge that accepted the last beat.
- Empty: after the last pop, `m_axis_tvalid` goes low after that edge.
- Pointer wrap-around is seamless; ordering is preserved across wraps.
- A push attempted while full is not accepted, so no overwrite occurs. A pop cannot occur while empty, so no underflow occurs.

## Test plan
- Reset, then write 0x11111111, 0x22222222, 0x33333333 with `m_axis_tready` = 0:
  - `count` = 3 and head = 0x11111111;
  - raising `m_axis_tready` yields the three words in order, then `m_axis_tvalid` = 0.
- Write 16 beats (0..15) with the consumer stalled:
  - `s_axis_tready` = 0 after the 16th beat and `count` = 16;
  - a 17th valid beat (0xDEAD) is not accepted;
  - draining returns 0..15 only.
- Hold `s_axis_tvalid` and `m_axis_tready` high for 100 cycles with an incrementing pattern: output matches the input sequence with 1-cycle latency, `count` never exceeds 1, and no bubbles appear.
- Random valid/ready at 50% on each side for 1000 beats: the scoreboard shows in-order, lossless transfer; `count` always equals pushes minus pops; the pointers wrap more than once.
- Fill to 10 beats, assert `rst` for one cycle mid-stream:
  - `m_axis_tvalid` = 0, `count` = 0, `s_axis_tready` = 0 during reset;
  - the next written word (0xA5A5A5A5) is the next word read.
- Fill the FIFO, then hold the consumer low for 5 cycles while toggling `s_axis_tdata`: `m_axis_tdata` stays stable at the head value.
